ps2_frame_rx: RTL and testbench
===============================

# ps2_frame_rx

PS/2 device-to-host frame receiver. Takes the raw `ps2c`/`ps2d` lines from the keyboard and reconstructs each 11-bit frame: start, 8 data bits LSB first, odd parity, stop. Each received byte is delivered to the downstream keyboard/scan-code logic as a byte plus a one-cycle strobe. The block also synchronizes and de-glitches the PS/2 clock, and reports framing, parity and timeout errors.

## Interface
Parameters:
- `FILTER_LEN`, 8: consecutive `clk` cycles the synchronized `ps2c` must hold a new level before the filtered clock follows it.
- `TIMEOUT_CYCLES`, 100000: maximum `clk` cycles between filtered falling edges inside a frame (2 ms at 50 MHz).
- `CHECK_STOP`, 1: 1 = stop bit must be 1; 0 = stop bit value ignored.

Ports:
- `clk` in 1: system clock, at least 4× faster than `ps2c`.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `ps2c` in 1: raw PS/2 clock, asynchronous.
- `ps2d` in 1: raw PS/2 data, asynchronous.
- `rx_data` out 8: last correctly received byte.
- `rx_valid` out 1: one-cycle pulse when `rx_data` is updated.
- `rx_err` out 1: one-cycle pulse when a frame is rejected.
- `err_code` out 2: 00 start, 01 parity, 10 stop, 11 timeout. Meaningful only while `rx_err` = 1.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- Input conditioning:
  - `ps2c` and `ps2d` each pass through a 2-flop synchronizer.
  - Filtered clock `ps2c_f` resets to 1. It takes the synchronized value only after that value has differed from `ps2c_f` for `FILTER_LEN` consecutive cycles. Any disagreement shorter than that restarts the count.
  - `fall` is a 1-cycle internal strobe on each 1→0 transition of `ps2c_f`.
  - On `fall`, the synchronized `ps2d` is the sampled bit.
- FSM states:
  - IDLE:
    - On `fall` with bit 0, go to DATA and clear the bit count.
    - On `fall` with bit 1, pulse `rx_err` with code 00 and stay in IDLE.
  - DATA: on each `fall`, shift the bit into `shreg[7]` (right shift, LSB first). After the 8th bit, go to PARITY.
  - PARITY: on `fall`, store the parity bit and go to STOP.
  - STOP: on `fall`, evaluate the frame and go to IDLE:
    - Parity error when `^{shreg, par}` = 0.
    - Stop error when `CHECK_STOP` = 1 and the stop bit = 0.
    - Priority: parity over stop.
    - Good frame: `rx_data` ← `shreg`, pulse `rx_valid`.
    - Bad frame: pulse `rx_err` with its code; `rx_data` is unchanged.
- Watchdog:
  - Counter runs in every state except IDLE and clears on each `fall` and on entry to IDLE.
  - When it reaches `TIMEOUT_CYCLES`, pulse `rx_err` with code 11, discard the partial frame and go to IDLE.
  - A `fall` in the same cycle as expiry wins: no timeout is raised.
- `rx_valid` and `rx_err` are never high in the same cycle.
- Width: bit counter is 3 bits with an explicit terminal at 7. Watchdog counter is `$clog2(TIMEOUT_CYCLES+1)` bits and never wraps.

## Timing
- Reset values: `rx_data`=0x00, `rx_valid`=0, `rx_err`=0, `err_code`=00, `busy`=0, FSM=IDLE, `ps2c_f`=1, all counters 0.
- `rst` mid-frame: the next cycle is IDLE with `busy`=0, the partial frame is discarded, and no pulse is issued.
- Latency from a raw `ps2c` falling edge to internal `fall`: 2 (sync) + `FILTER_LEN` cycles.
- `rx_valid`, `rx_err` and `err_code` are registered. They assert in the cycle after the `fall` that samples the stop bit, or after the timeout terminal count.
- `busy` rises the cycle after the start-bit `fall`. It falls in the same cycle that `rx_valid`/`rx_err` asserts.
- No backpressure. The consumer must take `rx_data` on `rx_valid`. `rx_data` is held until the next good frame.
- Back-to-back frames need no idle gap: a start-bit `fall` may arrive on the first cycle in IDLE.

## Test plan
- Frame 0xE0 (parity 0, stop 1), `ps2c` at 10 kHz, `clk` at 50 MHz → exactly one `rx_valid`, `rx_data`=0xE0, `rx_err` never asserted.
- Frames 0xE0, 0x72, 0xF0, 0xE0, 0x72 back-to-back → five `rx_valid` pulses with those values in order; `busy` low between frames.
- Frame 0x72 sent with parity 0 (correct is 1) → `rx_err`, `err_code`=01, `rx_data` keeps the prior 0xE0.
- 3-cycle low glitch on `ps2c` in IDLE with `FILTER_LEN`=8 → `busy` stays 0, no pulses.
- Frame aborted after 4 data bits with `ps2c` held high → `rx_err` with `err_code`=11 after `TIMEOUT_CYCLES`, then `busy`=0. A following full 0x1D frame yields `rx_valid` with `rx_data`=0x1D.
- Frame 0xF0 sent with stop bit 0:
  - `CHECK_STOP`=1 → `err_code`=10.
  - `CHECK_STOP`=0 → `rx_valid`, `rx_data`=0xF0.
  - `rst` pulsed after bit 5 → no pulse; the next frame is received correctly.

Source files
------------

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host frame receiver.
// Synchronizes and de-glitches ps2c, samples ps2d on each filtered falling
// edge, and reassembles start / 8 data (LSB first) / odd parity / stop.
//
// Ports:
//   clk      in   system clock (>= 4x ps2c)
//   rst      in   synchronous active-high reset
//   ps2c     in   raw PS/2 clock (asynchronous)
//   ps2d     in   raw PS/2 data (asynchronous)
//   rx_data  out  last correctly received byte
//   rx_valid out  one-cycle pulse when rx_data is updated
//   rx_err   out  one-cycle pulse when a frame is rejected
//   err_code out  00 start, 01 parity, 10 stop, 11 timeout (valid with rx_err)
//   busy     out  high whenever the FSM is not idle
//
// state  | meaning
// IDLE   | waiting for a start bit
// DATA   | shifting in the 8 data bits
// PARITY | waiting for the parity bit
// STOP   | waiting for the stop bit, then judge the frame
module ps2_frame_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CHECK_STOP     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic             c_s1, c_s2, d_s1, d_s2;
  logic             ps2c_f;
  logic [FLT_W-1:0] flt_cnt;
  logic             fall;
  logic [1:0]       state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             par;
  logic [WD_W-1:0]  wd_cnt;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      c_s1     <= 1'b1;
      c_s2     <= 1'b1;
      d_s1     <= 1'b1;
      d_s2     <= 1'b1;
      ps2c_f   <= 1'b1;
      flt_cnt  <= '0;
      fall     <= 1'b0;
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      wd_cnt   <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      err_code <= '0;
    end else begin
      c_s1 <= ps2c;
      c_s2 <= c_s1;
      d_s1 <= ps2d;
      d_s2 <= d_s1;

      // Filtered clock follows only after FILTER_LEN consecutive disagreeing
      // cycles; fall is raised in the same cycle ps2c_f drops, so it lines up
      // with the data bit that was stable while the clock was settling.
      fall <= 1'b0;
      if (c_s2 != ps2c_f) begin
        if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
          ps2c_f  <= c_s2;
          flt_cnt <= '0;
          fall    <= ~c_s2;
        end else begin
          flt_cnt <= flt_cnt + 1'b1;
        end
      end else begin
        flt_cnt <= '0;
      end

      rx_valid <= 1'b0;
      rx_err   <= 1'b0;

      if (state == IDLE) begin
        wd_cnt <= '0;
        if (fall) begin
          if (!d_s2) begin
            state   <= DATA;
            bit_cnt <= '0;
          end else begin
            rx_err   <= 1'b1;
            err_code <= 2'b00;
          end
        end
      end else if (fall) begin
        // A fall coinciding with watchdog expiry takes precedence.
        wd_cnt <= '0;
        case (state)
          DATA: begin
            shreg <= {d_s2, shreg[7:1]};
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          PARITY: begin
            par   <= d_s2;
            state <= STOP;
          end
          default: begin
            state <= IDLE;
            if ((^{shreg, par}) == 1'b0) begin
              rx_err   <= 1'b1;
              err_code <= 2'b01;
            end else if ((CHECK_STOP != 0) && !d_s2) begin
              rx_err   <= 1'b1;
              err_code <= 2'b10;
            end else begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end
          end
        endcase
      end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES)) begin
        wd_cnt   <= '0;
        state    <= IDLE;
        rx_err   <= 1'b1;
        err_code <= 2'b11;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_rx.sv
module tb_ps2_frame_rx;

  localparam int HALF = 30;
  localparam int TMO  = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2c_a = 1'b1, ps2d_a = 1'b1;
  logic       ps2c_b = 1'b1, ps2d_b = 1'b1;
  logic [7:0] rx_data_a, rx_data_b;
  logic       rx_valid_a, rx_valid_b, rx_err_a, rx_err_b, busy_a, busy_b;
  logic [1:0] err_code_a, err_code_b;

  always #5 clk = ~clk;

  ps2_frame_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO), .CHECK_STOP(1)) dut_a (
    .clk(clk), .rst(rst), .ps2c(ps2c_a), .ps2d(ps2d_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_err(rx_err_a),
    .err_code(err_code_a), .busy(busy_a));

  ps2_frame_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO), .CHECK_STOP(0)) dut_b (
    .clk(clk), .rst(rst), .ps2c(ps2c_b), .ps2d(ps2d_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_err(rx_err_b),
    .err_code(err_code_b), .busy(busy_b));

  typedef struct packed {
    logic       err;
    logic [1:0] code;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par_bad;
    logic       stop;
    logic       exp_err;
    logic [1:0] exp_code;
  } vec_t;

  exp_t       q_a[$];
  exp_t       q_b[$];
  logic [7:0] last_a = 8'h00;
  logic [7:0] last_b = 8'h00;
  int         tests = 0;
  int         fails = 0;
  logic       busy_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic err, input logic [1:0] code, input logic [7:0] data);
    if (!err) last_a = data;
    q_a.push_back({err, err ? code : 2'b00, last_a});
  endtask

  task automatic push_b(input logic err, input logic [1:0] code, input logic [7:0] data);
    if (!err) last_b = data;
    q_b.push_back({err, err ? code : 2'b00, last_b});
  endtask

  task automatic monitor();
    exp_t e;
    exp_t act;
    if (rx_valid_a && rx_err_a) check("a_valid_and_err", 1, 0);
    if (rx_valid_b && rx_err_b) check("b_valid_and_err", 1, 0);
    if (rx_valid_a || rx_err_a) begin
      act = {rx_err_a, rx_err_a ? err_code_a : 2'b00, rx_data_a};
      if (q_a.size() == 0) begin
        check("a_unexpected_pulse", {21'd0, act}, 32'hFFFF_FFFF);
      end else begin
        e = q_a.pop_front();
        check("a_pulse", {21'd0, act}, {21'd0, e});
      end
    end
    if (rx_valid_b || rx_err_b) begin
      act = {rx_err_b, rx_err_b ? err_code_b : 2'b00, rx_data_b};
      if (q_b.size() == 0) begin
        check("b_unexpected_pulse", {21'd0, act}, 32'hFFFF_FFFF);
      end else begin
        e = q_b.pop_front();
        check("b_pulse", {21'd0, act}, {21'd0, e});
      end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      monitor();
    end
  endtask

  task automatic send_bit(input logic sel, input logic b);
    if (sel) ps2d_b = b; else ps2d_a = b;
    tick(HALF);
    if (sel) ps2c_b = 1'b0; else ps2c_a = 1'b0;
    tick(HALF);
    if (sel) ps2c_b = 1'b1; else ps2c_a = 1'b1;
  endtask

  task automatic send_frame(input logic sel, input logic [7:0] d, input logic par_bad,
                            input logic stop);
    send_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
    send_bit(sel, (~^d) ^ par_bad);
    send_bit(sel, stop);
    if (sel) ps2d_b = 1'b1; else ps2d_a = 1'b1;
    tick(HALF);
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[1]  = '{8'h72, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[2]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[3]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[4]  = '{8'h72, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[5]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[6]  = '{8'h72, 1'b1, 1'b1, 1'b1, 2'b01};
    vecs[7]  = '{8'hF0, 1'b0, 1'b0, 1'b1, 2'b10};
    vecs[8]  = '{8'h55, 1'b1, 1'b0, 1'b1, 2'b01};
    vecs[9]  = '{8'h00, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[10] = '{8'hFF, 1'b0, 1'b1, 1'b0, 2'b00};

    tick(3);
    rst = 1'b0;
    tick(1);
    check("reset_rx_data", {24'd0, rx_data_a}, 32'h00);
    check("reset_rx_valid", {31'd0, rx_valid_a}, 32'd0);
    check("reset_rx_err", {31'd0, rx_err_a}, 32'd0);
    check("reset_err_code", {30'd0, err_code_a}, 32'd0);
    check("reset_busy", {31'd0, busy_a}, 32'd0);
    tick(HALF);

    // Frame table: back-to-back frames, parity/stop errors, parity priority.
    for (int v = 0; v < 11; v++) begin
      push_a(vecs[v].exp_err, vecs[v].exp_code, vecs[v].data);
      send_frame(1'b0, vecs[v].data, vecs[v].par_bad, vecs[v].stop);
      check($sformatf("vec%0d_drained", v), q_a.size(), 0);
      check($sformatf("vec%0d_busy_low", v), {31'd0, busy_a}, 32'd0);
      check($sformatf("vec%0d_rx_data", v), {24'd0, rx_data_a}, {24'd0, last_a});
    end

    // Start bit of 1 while idle.
    push_a(1'b1, 2'b00, 8'h00);
    send_bit(1'b0, 1'b1);
    tick(HALF);
    check("start_err_drained", q_a.size(), 0);
    check("start_err_busy", {31'd0, busy_a}, 32'd0);

    // Short low glitch on ps2c must be filtered out.
    ps2c_a = 1'b0;
    tick(3);
    ps2c_a = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      busy_seen = busy_seen | busy_a;
    end
    check("glitch_busy", {31'd0, busy_seen}, 32'd0);

    // Abort after 4 data bits: watchdog fires, then a clean frame follows.
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, i[0]);
    check("abort_busy_mid", {31'd0, busy_a}, 32'd1);
    push_a(1'b1, 2'b11, 8'h00);
    tick(TMO + 100);
    check("timeout_drained", q_a.size(), 0);
    check("timeout_busy", {31'd0, busy_a}, 32'd0);
    push_a(1'b0, 2'b00, 8'h1D);
    send_frame(1'b0, 8'h1D, 1'b0, 1'b1);
    check("after_timeout_drained", q_a.size(), 0);
    check("after_timeout_data", {24'd0, rx_data_a}, 32'h1D);

    // Stop bit ignored on the second instance.
    push_b(1'b0, 2'b00, 8'hF0);
    send_frame(1'b1, 8'hF0, 1'b0, 1'b0);
    check("nostop_drained", q_b.size(), 0);
    check("nostop_data", {24'd0, rx_data_b}, 32'hF0);

    // Reset after bit 5: frame dropped silently, next frame still good.
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    last_a = 8'h00;
    last_b = 8'h00;
    check("rst_mid_busy", {31'd0, busy_a}, 32'd0);
    check("rst_mid_data", {24'd0, rx_data_a}, 32'h00);
    tick(HALF);
    push_a(1'b0, 2'b00, 8'hA5);
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1);
    check("after_rst_drained", q_a.size(), 0);
    check("after_rst_data", {24'd0, rx_data_a}, 32'hA5);

    tick(20);
    check("final_q_a_empty", q_a.size(), 0);
    check("final_q_b_empty", q_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
